// File: rtl/hf_result_scoreboard_if.sv
// Expected-result push and DUT-result buses between a stimulus source and the result scoreboard.
interface hf_result_scoreboard_if #(
    parameter int chanW       = 1,
    parameter int formatWidth = 64
);
    logic                   exp_valid;
    logic                   exp_ready;
    logic [chanW-1:0]       exp_chan;
    logic [formatWidth-1:0] exp_out;
    logic [4:0]             exp_flags;
    logic                   exp_sqrtOp;

    logic                   dut_valid;
    logic [chanW-1:0]       dut_chan;
    logic [formatWidth-1:0] dut_out;
    logic [4:0]             dut_flags;
    logic                   dut_sqrtOp;

    modport master (
        output exp_valid, exp_chan, exp_out, exp_flags, exp_sqrtOp,
        output dut_valid, dut_chan, dut_out, dut_flags, dut_sqrtOp,
        input  exp_ready
    );

    modport slave (
        input  exp_valid, exp_chan, exp_out, exp_flags, exp_sqrtOp,
        input  dut_valid, dut_chan, dut_out, dut_flags, dut_sqrtOp,
        output exp_ready
    );
endinterface

// File: rtl/hf_result_scoreboard.sv
// Result scoreboard: per-channel in-order expected-result FIFOs, head compare, stats, first-error capture, LFSR issue throttle.
// Compare is combinational against the FIFO head; counters, sticky flags and capture are visible one cycle after dut_valid.
// DUT results are never stalled; exp_ready drops only while the addressed channel FIFO is full.
module hf_result_scoreboard #(
    parameter int          expWidth     = 11,
    parameter int          sigWidth     = 53,
    parameter int          depth        = 8,
    parameter int          numChannels  = 1,
    parameter int          maxNumErrors = 20,
    parameter int          maxDelayLog2 = 6,
    parameter logic [15:0] lfsrSeed     = 16'hACE1,
    parameter bit          nanLoose     = 1'b0,
    localparam int         formatWidth  = expWidth + sigWidth,
    localparam int         chanW        = (numChannels > 1) ? $clog2(numChannels) : 1
) (
    input  logic                   clock,
    input  logic                   nReset,
    hf_result_scoreboard_if.slave  bus,
    output logic                   throttle_ok,
    output logic [31:0]            pass_count,
    output logic [31:0]            error_count,
    output logic                   spurious,
    output logic                   stop,
    output logic                   idle,
    output logic                   err_valid,
    output logic [chanW-1:0]       err_chan,
    output logic [formatWidth-1:0] err_expect_out,
    output logic [4:0]             err_expect_flags,
    output logic [formatWidth-1:0] err_actual_out,
    output logic [4:0]             err_actual_flags
);
    localparam int aw     = $clog2(depth);
    localparam int nSlots = 1 << chanW;

    typedef struct packed {
        logic [formatWidth-1:0] out;
        logic [4:0]             flags;
        logic                   sqrtOp;
    } entry_t;

    // Slots beyond numChannels read as permanently full and empty, so stray channel ids never push or pop.
    logic [nSlots-1:0] full_v;
    logic [nSlots-1:0] empty_v;
    entry_t            head_v [nSlots];

    entry_t push_ent;
    entry_t head;
    logic   push_ok;
    logic   pop_ok;
    logic   miss;
    logic   exp_nan;
    logic   act_nan;
    logic   out_match;
    logic   match;
    logic   err_ev;

    assign push_ent      = '{out: bus.exp_out, flags: bus.exp_flags, sqrtOp: bus.exp_sqrtOp};
    assign bus.exp_ready = !full_v[bus.exp_chan];
    assign push_ok       = bus.exp_valid && bus.exp_ready;
    assign miss          = bus.dut_valid && empty_v[bus.dut_chan];
    assign pop_ok        = bus.dut_valid && !empty_v[bus.dut_chan];
    assign head          = head_v[bus.dut_chan];

    for (genvar c = 0; c < nSlots; c++) begin : g_ch
        if (c < numChannels) begin : g_real
            logic [aw:0] wr_ptr;
            logic [aw:0] rd_ptr;
            entry_t      mem [depth];
            logic        push_here;
            logic        pop_here;

            assign push_here = push_ok && (bus.exp_chan == chanW'(c));
            assign pop_here  = pop_ok && (bus.dut_chan == chanW'(c));
            assign full_v[c]  = (wr_ptr == {~rd_ptr[aw], rd_ptr[aw-1:0]});
            assign empty_v[c] = (wr_ptr == rd_ptr);
            assign head_v[c]  = mem[rd_ptr[aw-1:0]];

            always_ff @(posedge clock) begin
                if (push_here) begin
                    mem[wr_ptr[aw-1:0]] <= push_ent;
                end
            end

            always_ff @(posedge clock) begin
                if (!nReset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push_here) wr_ptr <= wr_ptr + 1'b1;
                    if (pop_here)  rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end else begin : g_pad
            assign full_v[c]  = 1'b1;
            assign empty_v[c] = 1'b1;
            assign head_v[c]  = '0;
        end
    end

    // NaN: exponent all ones with a nonzero fraction; sign and payload are ignored in loose mode.
    assign exp_nan   = (&head.out[formatWidth-2 -: expWidth]) && (|head.out[sigWidth-2:0]);
    assign act_nan   = (&bus.dut_out[formatWidth-2 -: expWidth]) && (|bus.dut_out[sigWidth-2:0]);
    assign out_match = (head.out == bus.dut_out) || (nanLoose && exp_nan && act_nan);
    assign match     = out_match && (head.flags == bus.dut_flags) && (head.sqrtOp == bus.dut_sqrtOp);
    assign err_ev    = miss || (pop_ok && !match);

    always_ff @(posedge clock) begin
        if (!nReset) begin
            pass_count       <= '0;
            error_count      <= '0;
            spurious         <= 1'b0;
            stop             <= 1'b0;
            err_valid        <= 1'b0;
            err_chan         <= '0;
            err_expect_out   <= '0;
            err_expect_flags <= '0;
            err_actual_out   <= '0;
            err_actual_flags <= '0;
        end else begin
            if (pop_ok && match && (pass_count != '1)) pass_count <= pass_count + 32'd1;
            if (err_ev && (error_count != '1))         error_count <= error_count + 32'd1;
            if (miss) spurious <= 1'b1;
            if (error_count >= 32'(maxNumErrors)) stop <= 1'b1;
            if (err_ev && !err_valid) begin
                err_valid        <= 1'b1;
                err_chan         <= bus.dut_chan;
                err_expect_out   <= miss ? '0 : head.out;
                err_expect_flags <= miss ? '0 : head.flags;
                err_actual_out   <= bus.dut_out;
                err_actual_flags <= bus.dut_flags;
            end
        end
    end

    // Galois LFSR for x^16+x^14+x^13+x^11+1, free-running; its low bits seed the post-push delay.
    logic [15:0]             lfsr;
    logic [maxDelayLog2-1:0] delay;

    always_ff @(posedge clock) begin
        if (!nReset) begin
            lfsr  <= lfsrSeed;
            delay <= '0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (push_ok)             delay <= lfsr[maxDelayLog2-1:0];
            else if (delay != '0)    delay <= delay - 1'b1;
        end
    end

    assign throttle_ok = (delay == '0);
    assign idle        = (&empty_v) && throttle_ok;
endmodule

// File: tb/tb_hf_result_scoreboard.sv
// Bench for hf_result_scoreboard: strict and NaN-loose instances share one stimulus stream against a queue-based model.
module tb_hf_result_scoreboard;
    localparam int          DEPTH = 8;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;

    typedef struct {
        logic [63:0] out;
        logic [4:0]  fl;
        logic        sq;
    } exp_t;

    logic clock  = 1'b0;
    logic nReset = 1'b0;
    always #5 clock = ~clock;

    hf_result_scoreboard_if #(.chanW(1), .formatWidth(64)) ifa ();
    hf_result_scoreboard_if #(.chanW(1), .formatWidth(64)) ifb ();

    assign ifb.exp_valid  = ifa.exp_valid;
    assign ifb.exp_chan   = ifa.exp_chan;
    assign ifb.exp_out    = ifa.exp_out;
    assign ifb.exp_flags  = ifa.exp_flags;
    assign ifb.exp_sqrtOp = ifa.exp_sqrtOp;
    assign ifb.dut_valid  = ifa.dut_valid;
    assign ifb.dut_chan   = ifa.dut_chan;
    assign ifb.dut_out    = ifa.dut_out;
    assign ifb.dut_flags  = ifa.dut_flags;
    assign ifb.dut_sqrtOp = ifa.dut_sqrtOp;

    logic        a_thr, a_spur, a_stop, a_idle, a_ev;
    logic [31:0] a_pass, a_err;
    logic [0:0]  a_echan;
    logic [63:0] a_eexp, a_eact;
    logic [4:0]  a_eexpf, a_eactf;
    logic        b_thr, b_spur, b_stop, b_idle, b_ev;
    logic [31:0] b_pass, b_err;
    logic [0:0]  b_echan;
    logic [63:0] b_eexp, b_eact;
    logic [4:0]  b_eexpf, b_eactf;

    hf_result_scoreboard #(.depth(DEPTH), .numChannels(2), .maxNumErrors(2), .nanLoose(1'b0)) dut_a (
        .clock(clock), .nReset(nReset), .bus(ifa),
        .throttle_ok(a_thr), .pass_count(a_pass), .error_count(a_err), .spurious(a_spur),
        .stop(a_stop), .idle(a_idle), .err_valid(a_ev), .err_chan(a_echan),
        .err_expect_out(a_eexp), .err_expect_flags(a_eexpf),
        .err_actual_out(a_eact), .err_actual_flags(a_eactf)
    );

    hf_result_scoreboard #(.depth(DEPTH), .numChannels(2), .maxNumErrors(2), .nanLoose(1'b1)) dut_b (
        .clock(clock), .nReset(nReset), .bus(ifb),
        .throttle_ok(b_thr), .pass_count(b_pass), .error_count(b_err), .spurious(b_spur),
        .stop(b_stop), .idle(b_idle), .err_valid(b_ev), .err_chan(b_echan),
        .err_expect_out(b_eexp), .err_expect_flags(b_eexpf),
        .err_actual_out(b_eact), .err_actual_flags(b_eactf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    exp_t        q0[$];
    exp_t        q1[$];
    int          m_pass_a, m_err_a, m_pass_b, m_err_b;
    bit          m_spur, m_errv;
    logic [0:0]  m_echan;
    logic [63:0] m_eexp, m_eact;
    logic [4:0]  m_eexpf, m_eactf;
    bit          drv_acc = 1'b0;
    logic [15:0] m_lfsr;
    int          m_delay = 0;
    int          m_last = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    // Throttle reference: LFSR x^16+x^14+x^13+x^11+1, delay loaded from its low 6 bits on an accepted push.
    always @(posedge clock) begin
        if (!nReset) begin
            m_lfsr  = SEED;
            m_delay = 0;
        end else begin
            if (drv_acc) begin
                m_delay = int'(m_lfsr[5:0]);
                m_last  = m_delay;
            end else if (m_delay != 0) begin
                m_delay--;
            end
            m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    task automatic capture(input logic [0:0] ch, input logic [63:0] eo, input logic [4:0] ef,
                           input logic [63:0] ao, input logic [4:0] af);
        if (!m_errv) begin
            m_errv  = 1'b1;
            m_echan = ch;
            m_eexp  = eo;
            m_eexpf = ef;
            m_eact  = ao;
            m_eactf = af;
        end
    endtask

    task automatic clear_inputs();
        ifa.exp_valid  = 1'b0; ifa.exp_chan = '0; ifa.exp_out = '0; ifa.exp_flags = '0; ifa.exp_sqrtOp = 1'b0;
        ifa.dut_valid  = 1'b0; ifa.dut_chan = '0; ifa.dut_out = '0; ifa.dut_flags = '0; ifa.dut_sqrtOp = 1'b0;
    endtask

    // One clock of stimulus: optional push and optional DUT result; the model decides acceptance and match.
    task automatic cyc(input bit dp, input logic [0:0] pch, input logic [63:0] pout, input logic [4:0] pfl,
                       input logic psq, input bit dr, input logic [0:0] rch, input bit rhead,
                       input logic [63:0] rout, input logic [4:0] rfl, input logic rsq);
        exp_t h, e;
        int   sz;
        bit   acc, sp, sa, sb;
        sz  = (pch == 1'b1) ? q1.size() : q0.size();
        acc = dp && (sz < DEPTH);
        ifa.exp_valid = dp; ifa.exp_chan = pch; ifa.exp_out = pout; ifa.exp_flags = pfl; ifa.exp_sqrtOp = psq;
        if (dr) begin
            sp = (rch == 1'b1) ? (q1.size() == 0) : (q0.size() == 0);
            if (sp) begin
                m_err_a++; m_err_b++; m_spur = 1'b1;
                capture(rch, 64'd0, 5'd0, rout, rfl);
            end else begin
                h = (rch == 1'b1) ? q1.pop_front() : q0.pop_front();
                if (rhead) begin rout = h.out; rfl = h.fl; rsq = h.sq; end
                sa = (h.out == rout) && (h.fl == rfl) && (h.sq == rsq);
                sb = ((h.out == rout) || (is_nan(h.out) && is_nan(rout))) && (h.fl == rfl) && (h.sq == rsq);
                if (sa) m_pass_a++; else begin m_err_a++; capture(rch, h.out, h.fl, rout, rfl); end
                if (sb) m_pass_b++; else m_err_b++;
            end
            ifa.dut_valid = 1'b1; ifa.dut_chan = rch; ifa.dut_out = rout; ifa.dut_flags = rfl; ifa.dut_sqrtOp = rsq;
        end
        if (acc) begin
            e.out = pout; e.fl = pfl; e.sq = psq;
            if (pch == 1'b1) q1.push_back(e); else q0.push_back(e);
        end
        drv_acc = acc;
        #1;
        chk("exp_ready", ifa.exp_ready, sz < DEPTH);
        @(posedge clock);
        #1;
        drv_acc = 1'b0;
        clear_inputs();
        chk("throttle_ok", a_thr, m_delay == 0);
    endtask

    task automatic push(input logic [0:0] ch, input logic [63:0] o, input logic [4:0] f, input logic s);
        cyc(1'b1, ch, o, f, s, 1'b0, 1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    endtask

    task automatic ret_head(input logic [0:0] ch);
        cyc(1'b0, ch, 64'd0, 5'd0, 1'b0, 1'b1, ch, 1'b1, 64'd0, 5'd0, 1'b0);
    endtask

    task automatic ret(input logic [0:0] ch, input logic [63:0] o, input logic [4:0] f, input logic s);
        cyc(1'b0, ch, 64'd0, 5'd0, 1'b0, 1'b1, ch, 1'b0, o, f, s);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_thr(output int n);
        n = 0;
        while (!a_thr && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("throttle_timeout", n < 100, 1'b1);
    endtask

    task automatic do_reset();
        nReset = 1'b0;
        drv_acc = 1'b0;
        clear_inputs();
        q0.delete(); q1.delete();
        m_pass_a = 0; m_err_a = 0; m_pass_b = 0; m_err_b = 0;
        m_spur = 1'b0; m_errv = 1'b0;
        m_echan = '0; m_eexp = '0; m_eact = '0; m_eexpf = '0; m_eactf = '0;
        repeat (2) @(posedge clock);
        #1;
        nReset = 1'b1;
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".pass_a"}, a_pass, m_pass_a);
        chk({tag, ".err_a"}, a_err, m_err_a);
        chk({tag, ".pass_b"}, b_pass, m_pass_b);
        chk({tag, ".err_b"}, b_err, m_err_b);
        chk({tag, ".spurious"}, a_spur, m_spur);
        chk({tag, ".err_valid"}, a_ev, m_errv);
        if (m_errv) begin
            chk({tag, ".err_chan"}, a_echan, m_echan);
            chk({tag, ".err_exp"}, a_eexp, m_eexp);
            chk({tag, ".err_expf"}, a_eexpf, m_eexpf);
            chk({tag, ".err_act"}, a_eact, m_eact);
            chk({tag, ".err_actf"}, a_eactf, m_eactf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_inputs();
        do_reset();
        chk("rst.exp_ready", ifa.exp_ready, 1'b1);
        chk("rst.throttle_ok", a_thr, 1'b1);
        chk("rst.idle", a_idle, 1'b1);
        chk("rst.stop", a_stop, 1'b0);
        check_stats("rst");

        // Three matching results returned after a gap.
        repeat (3) push(1'b0, ONE, 5'd0, 1'b0);
        idle_cycles(10);
        repeat (3) ret_head(1'b0);
        check_stats("match3");
        wait_thr(n);
        chk("match3.idle", a_idle, 1'b1);

        // First mismatch captured, second leaves the capture alone and trips stop.
        push(1'b0, ONE, 5'd0, 1'b0);
        ret(1'b0, TWO, 5'd0, 1'b0);
        idle_cycles(1);
        chk("mis1.stop", a_stop, 1'b0);
        check_stats("mis1");
        push(1'b0, 64'h1234, 5'd3, 1'b0);
        ret(1'b0, 64'h5678, 5'd4, 1'b0);
        idle_cycles(1);
        chk("mis2.stop", a_stop, 1'b1);
        check_stats("mis2");

        do_reset();
        chk("rst2.stop", a_stop, 1'b0);
        chk("rst2.throttle_ok", a_thr, 1'b1);
        chk("rst2.idle", a_idle, 1'b1);
        check_stats("rst2");

        // NaN handling, then flag and sqrtOp mismatches.
        push(1'b0, 64'h7FF8000000000000, 5'd0, 1'b0);
        ret(1'b0, 64'hFFF0000000000001, 5'd0, 1'b0);
        check_stats("nan");
        push(1'b0, ONE, 5'd1, 1'b0);
        ret(1'b0, ONE, 5'd2, 1'b0);
        push(1'b0, ONE, 5'd0, 1'b1);
        ret(1'b0, ONE, 5'd0, 1'b0);
        check_stats("flags_sqrt");

        // Fill, blocked push with same-cycle pop, then wrap-around traffic.
        do_reset();
        for (int i = 0; i < 8; i++) push(1'b0, 64'h100 + 64'(i), 5'(i), i[0]);
        push(1'b0, 64'hDEAD, 5'd0, 1'b0);
        cyc(1'b1, 1'b0, 64'hBEEF, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 64'd0, 5'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 64'h200 + 64'(i), 5'(i + 3), i[1], 1'b1, 1'b0, 1'b1, 64'd0, 5'd0, 1'b0);
        repeat (5) ret_head(1'b0);
        check_stats("wrap");

        // Reset with entries still queued, then two interleaved channels.
        do_reset();
        push(1'b0, ONE, 5'd1, 1'b0);
        push(1'b1, TWO, 5'd2, 1'b1);
        push(1'b0, 64'h3FF8000000000000, 5'd0, 1'b0);
        push(1'b1, 64'h4008000000000000, 5'd4, 1'b1);
        ret_head(1'b1);
        ret_head(1'b1);
        ret_head(1'b0);
        ret_head(1'b0);
        check_stats("chan2");
        ret(1'b1, ONE, 5'd7, 1'b0);
        check_stats("spur_ch1");
        cyc(1'b1, 1'b0, TWO, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, TWO, 5'd0, 1'b0);
        ret_head(1'b0);
        check_stats("push_pop_empty");

        // Post-push throttle delay equals the LFSR low bits.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            idle_cycles(k * 3 + 1);
            push(1'b0, ONE, 5'd0, 1'b0);
            wait_thr(n);
            chk("thr_delay", n, m_last);
            ret_head(1'b0);
        end
        check_stats("thr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
